// File: rtl/inst_ram_loader.sv
// Streams 32-bit instruction words into a byte-wide instruction RAM, four big-endian
// bytes per word, and holds the CPU until the image has been loaded.
module inst_ram_loader #(
  parameter int ADDR_W    = 8,
  parameter int DEPTH     = 256,
  parameter int BASE_ADDR = 0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [31:0]       word_in,
  input  logic              word_valid,
  input  logic              word_last,
  output logic              word_ready,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [7:0]        mem_data,
  output logic              busy,
  output logic              done,
  output logic              err_full,
  output logic              cpu_hold,
  output logic [ADDR_W-2:0] word_count
);

  typedef enum logic [2:0] {
    IDLE, LOAD_WAIT, WR_B0, WR_B1, WR_B2, WR_B3, DONE, FULL
  } state_e;

  localparam logic [ADDR_W-1:0] BASE     = ADDR_W'(BASE_ADDR);
  localparam logic [ADDR_W-1:0] LAST_PTR = ADDR_W'(DEPTH - 4);

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   ptr_q, ptr_d;
  logic [31:0]         word_q, word_d;
  logic                last_q, last_d;
  logic [ADDR_W-2:0]   count_q, count_d;

  logic                word_ready_q, word_ready_d;
  logic                mem_we_q, mem_we_d;
  logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
  logic [7:0]          mem_data_q, mem_data_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic                err_full_q, err_full_d;
  logic                cpu_hold_q, cpu_hold_d;

  always_comb begin
    // NOTE: every signal gets a default first so no path through the case leaves it unassigned (no latch).
    state_d = state_q;
    ptr_d   = ptr_q;
    word_d  = word_q;
    last_d  = last_q;
    count_d = count_q;

    unique case (state_q)
      IDLE, DONE, FULL: begin
        if (start) begin
          state_d = LOAD_WAIT;
          ptr_d   = BASE;
          count_d = '0;
        end
      end
      LOAD_WAIT: begin
        if (word_valid && word_ready_q) begin
          word_d  = word_in;
          last_d  = word_last;
          state_d = WR_B0;
        end
      end
      WR_B0: state_d = WR_B1;
      WR_B1: state_d = WR_B2;
      WR_B2: state_d = WR_B3;
      WR_B3: begin
        ptr_d   = ptr_q + ADDR_W'(4);
        count_d = count_q + 1'b1;
        // A last word that exactly fills the RAM is a clean finish, not an overflow.
        if (last_q)                  state_d = DONE;
        else if (ptr_q == LAST_PTR)  state_d = FULL;
        else                         state_d = LOAD_WAIT;
      end
      default: state_d = IDLE;
    endcase

    // Outputs are decoded from the next state so they can be registered with no extra latency.
    word_ready_d = (state_d == LOAD_WAIT);
    busy_d       = (state_d inside {LOAD_WAIT, WR_B0, WR_B1, WR_B2, WR_B3});
    done_d       = (state_d == DONE);
    err_full_d   = (state_d == FULL);
    cpu_hold_d   = (state_d != DONE);
    mem_we_d     = (state_d inside {WR_B0, WR_B1, WR_B2, WR_B3});
    mem_addr_d   = ptr_d;
    mem_data_d   = '0;
    unique case (state_d)
      WR_B0: begin mem_addr_d = ptr_d;                mem_data_d = word_d[31:24]; end
      WR_B1: begin mem_addr_d = ptr_d + ADDR_W'(1);   mem_data_d = word_d[23:16]; end
      WR_B2: begin mem_addr_d = ptr_d + ADDR_W'(2);   mem_data_d = word_d[15:8];  end
      WR_B3: begin mem_addr_d = ptr_d + ADDR_W'(3);   mem_data_d = word_d[7:0];   end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      ptr_q        <= BASE;
      word_q       <= '0;
      last_q       <= 1'b0;
      count_q      <= '0;
      word_ready_q <= 1'b0;
      mem_we_q     <= 1'b0;
      mem_addr_q   <= BASE;
      mem_data_q   <= '0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      err_full_q   <= 1'b0;
      cpu_hold_q   <= 1'b1;
    end else begin
      // NOTE: non-blocking assignments so every flop samples the pre-edge values.
      state_q      <= state_d;
      ptr_q        <= ptr_d;
      word_q       <= word_d;
      last_q       <= last_d;
      count_q      <= count_d;
      word_ready_q <= word_ready_d;
      mem_we_q     <= mem_we_d;
      mem_addr_q   <= mem_addr_d;
      mem_data_q   <= mem_data_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      err_full_q   <= err_full_d;
      cpu_hold_q   <= cpu_hold_d;
    end
  end

  assign word_ready = word_ready_q;
  assign mem_we     = mem_we_q;
  assign mem_addr   = mem_addr_q;
  assign mem_data   = mem_data_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign err_full   = err_full_q;
  assign cpu_hold   = cpu_hold_q;
  assign word_count = count_q;

endmodule

// File: tb/tb_inst_ram_loader.sv
// Directed bench for inst_ram_loader: a byte RAM model captures writes and each
// phase compares outputs and RAM contents against hand-computed values.
module tb_inst_ram_loader;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [31:0] word_in;
  logic        word_valid;
  logic        word_last;
  logic        word_ready;
  logic        mem_we;
  logic [7:0]  mem_addr;
  logic [7:0]  mem_data;
  logic        busy;
  logic        done;
  logic        err_full;
  logic        cpu_hold;
  logic [6:0]  word_count;

  int n_vec = 0;
  int n_bad = 0;

  logic [7:0] ram [256];

  inst_ram_loader #(.ADDR_W(8), .DEPTH(256), .BASE_ADDR(0)) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .word_in    (word_in),
    .word_valid (word_valid),
    .word_last  (word_last),
    .word_ready (word_ready),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_data   (mem_data),
    .busy       (busy),
    .done       (done),
    .err_full   (err_full),
    .cpu_hold   (cpu_hold),
    .word_count (word_count)
  );

  always #5 clk = ~clk;

  always @(posedge clk) if (mem_we) ram[mem_addr] <= mem_data;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic pulse_start();
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
  endtask

  task automatic wait_ready();
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (word_ready === 1'b1) break;
    end
    check("ready_wait", word_ready, 1'b1);
  endtask

  // Sends one word and checks the four byte writes that follow the accept edge.
  task automatic send_word(input logic [31:0] w, input logic last, input logic [7:0] base,
                           input bit start_at_b1);
    logic [7:0] exp_b;
    wait_ready();
    word_in = w; word_last = last; word_valid = 1'b1;
    @(posedge clk);
    #1 word_valid = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      if (k == 2) start = 1'b0;
      exp_b = w[31 - 8*k -: 8];
      check("wr_we",    mem_we,     1'b1);
      check("wr_addr",  mem_addr,   base + 8'(k));
      check("wr_data",  mem_data,   exp_b);
      check("wr_ready", word_ready, 1'b0);
      if (k == 1 && start_at_b1) start = 1'b1;
    end
  endtask

  initial begin
    for (int i = 0; i < 256; i++) ram[i] = 8'h00;
    reset = 1'b1; start = 1'b0; word_in = '0; word_valid = 1'b0; word_last = 1'b0;

    // Reset values
    repeat (2) @(negedge clk);
    check("rst_ready", word_ready, 1'b0);
    check("rst_we",    mem_we,     1'b0);
    check("rst_addr",  mem_addr,   8'h00);
    check("rst_data",  mem_data,   8'h00);
    check("rst_busy",  busy,       1'b0);
    check("rst_done",  done,       1'b0);
    check("rst_err",   err_full,   1'b0);
    check("rst_hold",  cpu_hold,   1'b1);
    check("rst_cnt",   word_count, 7'd0);
    reset = 1'b0;

    // T1: single word with last
    pulse_start();
    check("t1_busy", busy, 1'b1);
    check("t1_hold", cpu_hold, 1'b1);
    send_word(32'hDB000001, 1'b1, 8'h00, 1'b0);
    @(negedge clk);
    check("t1_done",  done,       1'b1);
    check("t1_hold0", cpu_hold,   1'b0);
    check("t1_busy0", busy,       1'b0);
    check("t1_we0",   mem_we,     1'b0);
    check("t1_cnt",   word_count, 7'd1);
    check("t1_ram",   {ram[0], ram[1], ram[2], ram[3]}, 32'hDB000001);

    // T2: three words
    pulse_start();
    check("t2_done_clr", done, 1'b0);
    send_word(32'hE3A01005, 1'b0, 8'h00, 1'b0);
    send_word(32'hE2811001, 1'b0, 8'h04, 1'b0);
    send_word(32'hEAFFFFFE, 1'b1, 8'h08, 1'b0);
    @(negedge clk);
    check("t2_done", done, 1'b1);
    check("t2_cnt",  word_count, 7'd3);
    check("t2_w0", {ram[0], ram[1], ram[2],  ram[3]},  32'hE3A01005);
    check("t2_w1", {ram[4], ram[5], ram[6],  ram[7]},  32'hE2811001);
    check("t2_w2", {ram[8], ram[9], ram[10], ram[11]}, 32'hEAFFFFFE);

    // T3: 64 words without last -> FULL; byte at address a holds a
    pulse_start();
    for (int i = 0; i < 64; i++)
      send_word({8'(4*i), 8'(4*i+1), 8'(4*i+2), 8'(4*i+3)}, 1'b0, 8'(4*i), 1'b0);
    @(negedge clk);
    check("t3_err",  err_full,   1'b1);
    check("t3_hold", cpu_hold,   1'b1);
    check("t3_done", done,       1'b0);
    check("t3_busy", busy,       1'b0);
    check("t3_cnt",  word_count, 7'd64);
    check("t3_ram255", ram[255], 8'hFF);
    check("t3_ram128", ram[128], 8'h80);
    word_in = 32'h12345678; word_valid = 1'b1; word_last = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      check("t3_stall_ready", word_ready, 1'b0);
      check("t3_stall_we",    mem_we,     1'b0);
    end
    word_valid = 1'b0;

    // T4: 64 words, last on the 64th -> DONE with pointer wrapped; byte a holds ~a
    pulse_start();
    check("t4_err_clr", err_full, 1'b0);
    for (int i = 0; i < 64; i++)
      send_word(~{8'(4*i), 8'(4*i+1), 8'(4*i+2), 8'(4*i+3)}, (i == 63), 8'(4*i), 1'b0);
    @(negedge clk);
    check("t4_done", done,       1'b1);
    check("t4_err",  err_full,   1'b0);
    check("t4_addr", mem_addr,   8'h00);
    check("t4_we",   mem_we,     1'b0);
    check("t4_cnt",  word_count, 7'd64);
    @(negedge clk);
    check("t4_we2",  mem_we,     1'b0);
    check("t4_ram0",   ram[0],   8'hFF);
    check("t4_ram255", ram[255], 8'h00);

    // T5: start during WR_B1 is ignored; restart after DONE reloads from base
    pulse_start();
    send_word(32'h11223344, 1'b0, 8'h00, 1'b1);
    check("t5_busy_mid", busy, 1'b1);
    send_word(32'h55667788, 1'b1, 8'h04, 1'b0);
    @(negedge clk);
    check("t5_done", done, 1'b1);
    check("t5_cnt",  word_count, 7'd2);
    pulse_start();
    check("t5_done_clr", done,       1'b0);
    check("t5_hold",     cpu_hold,   1'b1);
    check("t5_ready",    word_ready, 1'b1);
    check("t5_cnt_clr",  word_count, 7'd0);
    send_word(32'hCAFEF00D, 1'b1, 8'h00, 1'b0);
    @(negedge clk);
    check("t5_done2", done, 1'b1);
    check("t5_ram", {ram[0], ram[1], ram[2], ram[3]}, 32'hCAFEF00D);
    check("t5_keep", {ram[4], ram[5], ram[6], ram[7]}, 32'h55667788);

    // T6: reset in WR_B2 aborts at once; valid without ready does nothing
    pulse_start();
    wait_ready();
    word_in = 32'hA5A5A5A5; word_last = 1'b0; word_valid = 1'b1;
    @(posedge clk);
    #1 word_valid = 1'b0;
    repeat (3) @(negedge clk);
    check("t6_we_b2",   mem_we,   1'b1);
    check("t6_addr_b2", mem_addr, 8'h02);
    #2 reset = 1'b1;
    #1;
    check("t6_we_rst",    mem_we,     1'b0);
    check("t6_hold_rst",  cpu_hold,   1'b1);
    check("t6_busy_rst",  busy,       1'b0);
    check("t6_ready_rst", word_ready, 1'b0);
    check("t6_addr_rst",  mem_addr,   8'h00);
    @(negedge clk) reset = 1'b0;
    word_in = 32'h0BADF00D; word_valid = 1'b1; word_last = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("t6_idle_we",    mem_we,     1'b0);
      check("t6_idle_ready", word_ready, 1'b0);
    end
    word_valid = 1'b0;
    check("t6_idle_done", done, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
